// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client single-word request arbiter and sequencer feeding the async SRAM controller.
// Build option SRAM_ARB_ROUND_ROBIN_EN: round-robin tie-break; when undefined, client 0 has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,

    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,

    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state, state_next;

    logic              elig0, elig1;
    logic              grant;
    logic              win;        // 0 = client 0, 1 = client 1
    logic              done;

    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              owner;

    // A client whose ack is high this cycle still holds req from the finished
    // access; masking it stops that stale request being served twice.
    assign elig0 = c0_req & ~c0_ack;
    assign elig1 = c1_req & ~c1_ack;
    assign grant = (state == IDLE) & mem_ready & (elig0 | elig1);

    // BUSY starts after the controller has taken the request, so ready is
    // already low there and a high ready can only mean completion.
    assign done  = (state == BUSY) & mem_ready;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last;

    assign win = (elig0 & elig1) ? ~last : elig1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (grant) begin
            last <= win;
        end
    end
`else
    assign win = ~elig0;
`endif

    // State register
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = BUSY;
            BUSY:    if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: the request strobe is a single-cycle pulse in ISSUE
    always_comb begin
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        if (state == ISSUE) begin
            mem_read_req  = ~cmd_we;
            mem_write_req = cmd_we;
        end
    end

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    // Command is captured once at grant; client fields are free to move afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            owner     <= 1'b0;
        end else if (grant) begin
            owner     <= win;
            cmd_we    <= win ? c1_we    : c0_we;
            cmd_addr  <= win ? c1_addr  : c0_addr;
            cmd_wdata <= win ? c1_wdata : c0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_ack   <= 1'b0;
            c1_ack   <= 1'b0;
            c0_rdata <= '0;
            c1_rdata <= '0;
        end else begin
            c0_ack <= done & ~owner;
            c1_ack <= done & owner;
            if (done && !cmd_we && !owner) c0_rdata <= mem_rdata;
            if (done && !cmd_we &&  owner) c1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized bench for sram_arbiter with a controller model and
// a transaction-level reference model compared every cycle. Honours SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              c0_req = 1'b0, c1_req = 1'b0;
    logic              c0_we = 1'b0, c1_we = 1'b0;
    logic [ADDR_W-1:0] c0_addr = '0, c1_addr = '0;
    logic [DATA_W-1:0] c0_wdata = '0, c1_wdata = '0;
    logic              c0_ack, c1_ack;
    logic [DATA_W-1:0] c0_rdata, c1_rdata;
    logic              mem_read_req, mem_write_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b1;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- controller model ----------------
    logic [DATA_W-1:0] ref_mem [int];
    int  k_cycles  = 3;
    bit  gap_mode  = 1'b0;
    bit  rand_ctrl = 1'b0;
    int  low_cnt   = 0;
    int  cur_k     = 0;
    bit  cur_gap   = 1'b0;
    bit  done_pend = 1'b0;
    bit  gap_pend  = 1'b0;

    function automatic logic [DATA_W-1:0] mem_val(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Samples the request mid-cycle; ready is low for K cycles after the
    // request cycle, then high; in gap mode it dips for one more cycle.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                mem_ready = 1'b1;
                low_cnt   = 0;
                done_pend = 1'b0;
                gap_pend  = 1'b0;
            end else if (mem_read_req || mem_write_req) begin
                cur_k   = rand_ctrl ? int'($urandom_range(1, 5)) : k_cycles;
                cur_gap = rand_ctrl ? 1'($urandom_range(0, 1)) : gap_mode;
                low_cnt = cur_k;
                if (mem_write_req) ref_mem[int'(mem_addr)] = mem_wdata;
                else               mem_rdata = mem_val(int'(mem_addr));
            end else if (low_cnt > 0) begin
                mem_ready = 1'b0;
                low_cnt--;
                if (low_cnt == 0) done_pend = 1'b1;
            end else if (done_pend) begin
                mem_ready = 1'b1;
                done_pend = 1'b0;
                gap_pend  = cur_gap;
            end else if (gap_pend) begin
                mem_ready = 1'b0;
                gap_pend  = 1'b0;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    // One in-flight transaction with its age in cycles since grant.
    bit                m_busy = 1'b0;
    int                m_age  = 0;
    bit                m_we   = 1'b0;
    int                m_owner = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    int                m_prev  = 1;
    bit                e_ack0 = 1'b0, e_ack1 = 1'b0;
    logic [DATA_W-1:0] e_rd0 = '0, e_rd1 = '0;

    task automatic model_reset();
        m_busy = 1'b0; m_age = 0; m_we = 1'b0; m_owner = 0;
        m_addr = '0; m_wdata = '0; m_prev = 1;
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
    endtask

    task automatic model_step();
        bit n0, n1, el0, el1;
        int w;
        n0 = 1'b0; n1 = 1'b0;
        el0 = c0_req && !e_ack0;
        el1 = c1_req && !e_ack1;
        if (m_busy) begin
            if (m_age >= 2 && mem_ready) begin
                if (m_owner == 1) n1 = 1'b1; else n0 = 1'b1;
                if (!m_we) begin
                    if (m_owner == 1) e_rd1 = mem_val(int'(m_addr));
                    else              e_rd0 = mem_val(int'(m_addr));
                end
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end else if (mem_ready && (el0 || el1)) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            w = (el0 && el1) ? 1 - m_prev : (el1 ? 1 : 0);
`else
            w = el0 ? 0 : 1;
`endif
            m_prev  = w;
            m_owner = w;
            m_we    = (w == 1) ? c1_we    : c0_we;
            m_addr  = (w == 1) ? c1_addr  : c0_addr;
            m_wdata = (w == 1) ? c1_wdata : c0_wdata;
            m_busy  = 1'b1;
            m_age   = 1;
        end
        e_ack0 = n0;
        e_ack1 = n1;
    endtask

    task automatic compare();
        bit strobe;
        strobe = m_busy && (m_age == 1);
        check("c0_ack",        32'(c0_ack),        32'(e_ack0));
        check("c1_ack",        32'(c1_ack),        32'(e_ack1));
        check("c0_rdata",      32'(c0_rdata),      32'(e_rd0));
        check("c1_rdata",      32'(c1_rdata),      32'(e_rd1));
        check("mem_read_req",  32'(mem_read_req),  32'(strobe && !m_we));
        check("mem_write_req", 32'(mem_write_req), 32'(strobe && m_we));
        check("mem_addr",      32'(mem_addr),      32'(m_addr));
        check("mem_wdata",     32'(mem_wdata),     32'(m_wdata));
        check("ack_exclusive", 32'(c0_ack & c1_ack), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            if (rst_n) compare();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_client(input int c, input logic req, input logic we,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (c == 0) begin
            c0_req = req; c0_we = we; c0_addr = a; c0_wdata = d;
        end else begin
            c1_req = req; c1_we = we; c1_addr = a; c1_wdata = d;
        end
    endtask

    // One request held through its ack cycle and dropped the cycle after.
    task automatic do_access(input int c, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input bit scramble,
                             output int g, output int iss, output int ack,
                             output int nreq, output bit hold_ok, output bit once_ok);
        @(negedge clk);
        set_client(c, 1'b1, we, a, d);
        g = cyc; iss = -1; ack = -1; nreq = 0; hold_ok = 1'b1; once_ok = 1'b1;
        for (int i = 0; i < 60 && ack < 0; i++) begin
            @(posedge clk); #1;
            if (mem_read_req || mem_write_req) begin
                nreq++;
                iss = cyc;
            end
            if (iss >= 0 && (mem_addr !== a || mem_wdata !== d)) hold_ok = 1'b0;
            if (((c == 0) ? c0_ack : c1_ack) === 1'b1) ack = cyc;
            if (scramble && iss == cyc) begin
                @(negedge clk);
                set_client(c, 1'b1, ~we, 17'($urandom), 16'($urandom));
            end
        end
        check("ack_within_budget", 32'(ack >= 0), 32'd1);
        @(posedge clk); #1;
        if (((c == 0) ? c0_ack : c1_ack) !== 1'b0) once_ok = 1'b0;
        if (mem_read_req || mem_write_req) nreq++;
        @(negedge clk);
        set_client(c, 1'b0, we, a, d);
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_read_req || mem_write_req) nreq++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within budget");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int g, iss, ack, nreq, acks_in_rst, wait_i;
        bit hold_ok, once_ok;
        int seq[$];
        int exp_seq[4];
        bit rdone[2];
        logic r, k;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        ref_mem[32'h10] = 16'hBEEF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_c0_ack",   32'(c0_ack), 32'd0);
        check("rst_c1_ack",   32'(c1_ack), 32'd0);
        check("rst_c0_rdata", 32'(c0_rdata), 32'd0);
        check("rst_c1_rdata", 32'(c1_rdata), 32'd0);
        check("rst_rd_req",   32'(mem_read_req), 32'd0);
        check("rst_wr_req",   32'(mem_write_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // c0 read at 0x00010 with K = 5
        k_cycles = 5;
        do_access(0, 1'b0, 17'h00010, 16'h0000, 1'b0, g, iss, ack, nreq, hold_ok, once_ok);
        check("t1_issue_cycle", 32'(iss - g), 32'd1);
        check("t1_ack_cycle",   32'(ack - g), 32'd8);
        check("t1_accesses",    32'(nreq), 32'd1);
        check("t1_rdata",       32'(c0_rdata), 32'hBEEF);
        check("t1_addr_hold",   32'(hold_ok), 32'd1);
        check("t1_ack_once",    32'(once_ok), 32'd1);

        // c1 write 0xA5A5 to 0x1FFFF with K = 3
        k_cycles = 3;
        do_access(1, 1'b1, 17'h1FFFF, 16'hA5A5, 1'b0, g, iss, ack, nreq, hold_ok, once_ok);
        check("t2_issue_cycle", 32'(iss - g), 32'd1);
        check("t2_ack_cycle",   32'(ack - g), 32'd6);
        check("t2_accesses",    32'(nreq), 32'd1);
        check("t2_wdata_hold",  32'(hold_ok), 32'd1);
        check("t2_ack_once",    32'(once_ok), 32'd1);
        check("t2_c1_rdata",    32'(c1_rdata), 32'd0);
        check("t2_mem_written", 32'(mem_val(32'h1FFFF)), 32'hA5A5);

        // Both clients request continuously for four accesses
        k_cycles = 2;
        gap_mode = 1'b1;
        @(negedge clk);
        set_client(0, 1'b1, 1'b0, 17'h00100, 16'h0);
        set_client(1, 1'b1, 1'b0, 17'h00200, 16'h0);
        seq.delete();
        for (int i = 0; i < 200 && seq.size() < 4; i++) begin
            @(posedge clk); #1;
            if (c0_ack) seq.push_back(0);
            if (c1_ack) seq.push_back(1);
        end
        @(negedge clk);
        set_client(0, 1'b0, 1'b0, 17'h00100, 16'h0);
        set_client(1, 1'b0, 1'b0, 17'h00200, 16'h0);
        gap_mode = 1'b0;
        check("t3_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_winner%0d", i), 32'((i < seq.size()) ? seq[i] : -1), 32'(exp_seq[i]));
        repeat (4) @(posedge clk);

        // Field changes after grant do not reach the controller
        do_access(0, 1'b1, 17'h0ABCD, 16'h1234, 1'b1, g, iss, ack, nreq, hold_ok, once_ok);
        check("t4_fields_hold", 32'(hold_ok), 32'd1);
        check("t4_accesses",    32'(nreq), 32'd1);

        // Reset during BUSY abandons the access
        k_cycles = 6;
        @(negedge clk);
        set_client(0, 1'b1, 1'b0, 17'h00040, 16'h0);
        wait_i = 0;
        while (mem_read_req !== 1'b1 && wait_i < 20) begin
            @(posedge clk); #1;
            wait_i++;
        end
        check("t5_issue_seen", 32'(mem_read_req), 32'd1);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("t5_c0_ack",   32'(c0_ack), 32'd0);
        check("t5_c1_ack",   32'(c1_ack), 32'd0);
        check("t5_c0_rdata", 32'(c0_rdata), 32'd0);
        check("t5_c1_rdata", 32'(c1_rdata), 32'd0);
        check("t5_req",      32'(mem_read_req | mem_write_req), 32'd0);
        check("t5_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_mem_wdata", 32'(mem_wdata), 32'd0);
        set_client(0, 1'b0, 1'b0, 17'h00040, 16'h0);
        acks_in_rst = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (c0_ack || c1_ack) acks_in_rst++;
        end
        check("t5_no_ack", 32'(acks_in_rst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k_cycles = 2;
        @(negedge clk);
        set_client(0, 1'b1, 1'b0, 17'h00010, 16'h0);
        set_client(1, 1'b1, 1'b1, 17'h00055, 16'h7E57);
        seq.delete();
        for (int i = 0; i < 80 && seq.size() < 2; i++) begin
            @(posedge clk); #1;
            if (c0_ack) begin
                seq.push_back(0);
                @(negedge clk);
                set_client(0, 1'b0, 1'b0, 17'h00010, 16'h0);
            end else if (c1_ack) begin
                seq.push_back(1);
                @(negedge clk);
                set_client(1, 1'b0, 1'b1, 17'h00055, 16'h7E57);
            end
        end
        set_client(0, 1'b0, 1'b0, 17'h00010, 16'h0);
        set_client(1, 1'b0, 1'b0, 17'h00055, 16'h0);
        check("t5_first_after_rst",  32'((seq.size() > 0) ? seq[0] : -1), 32'd0);
        check("t5_second_after_rst", 32'((seq.size() > 1) ? seq[1] : -1), 32'd1);
        check("t5_c0_rdata_after",   32'(c0_rdata), 32'hBEEF);
        repeat (4) @(posedge clk);

        // Randomized traffic against the reference model
        rand_ctrl = 1'b1;
        rdone[0] = 1'b0;
        rdone[1] = 1'b0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                r = (c == 0) ? c0_req : c1_req;
                k = (c == 0) ? c0_ack : c1_ack;
                if (r && k) begin
                    rdone[c] = 1'b1;
                end else if (!r || rdone[c]) begin
                    rdone[c] = 1'b0;
                    set_client(c, 1'($urandom_range(0, 2) != 0), 1'($urandom),
                               17'($urandom_range(0, 31)), 16'($urandom));
                end else if ($urandom_range(0, 3) == 0) begin
                    set_client(c, 1'b1, 1'($urandom), 17'($urandom_range(0, 31)), 16'($urandom));
                end
            end
        end
        @(negedge clk);
        wait_i = 0;
        while ((c0_req || c1_req) && wait_i < 100) begin
            if (c0_ack) set_client(0, 1'b0, 1'b0, '0, '0);
            if (c1_ack) set_client(1, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            wait_i++;
        end
        check("rand_drained", 32'(c0_req | c1_req), 32'd0);
        set_client(0, 1'b0, 1'b0, '0, '0);
        set_client(1, 1'b0, 1'b0, '0, '0);
        repeat (20) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-client request arbiter and sequencer that sits directly upstream of the async SRAM controller. It accepts single-word read/write requests from two clients, CPU (client 0) and DMA/video (client 1), and grants one at a time. It registers the granted command and drives the controller's level-sensitive `read_req`/`write_req`/`addr_in`/`write_data` inputs. It detects completion from the controller's `ready` falling and then rising, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 17: word address width.
- `DATA_W`, 16: data width.

Ports:
- `clk` in 1: single clock. Shared with the controller.
- `rst_n` in 1: asynchronous, active-low reset. The controller's active-high `rst` is driven from `~rst_n` at the top level.
- `c0_req`, `c1_req` in 1: request. Held high until the matching `cN_ack`.
- `c0_we`, `c1_we` in 1: 1 = write, 0 = read.
- `c0_addr`, `c1_addr` in `ADDR_W`: word address.
- `c0_wdata`, `c1_wdata` in `DATA_W`: write data.
- `c0_ack`, `c1_ack` out 1: one-cycle completion pulse.
- `c0_rdata`, `c1_rdata` out `DATA_W`: read data. Valid while `ack` is high and held until the next read for that client.
- `mem_read_req`, `mem_write_req` out 1: drive the controller's `read_req`/`write_req`.
- `mem_addr` out `ADDR_W`: drives the controller's `addr_in`. Stable from grant until completion.
- `mem_wdata` out `DATA_W`: drives the controller's `write_data`. Stable from grant until completion.
- `mem_rdata` in `DATA_W`: from the controller's `read_data`.
- `mem_ready` in 1: from the controller's `ready` (high while the controller is idle).

## Operation
- FSM states: `IDLE`, `ISSUE`, `BUSY`.
- `IDLE`:
  - A client is eligible if its `cN_req` = 1 and its `cN_ack` is not high this cycle. This ack-cycle masking prevents a stale request from being served twice.
  - If at least one client is eligible and `mem_ready` = 1, pick a winner.
  - Load `cmd_we`, `cmd_addr`, `cmd_wdata` and `owner` from the winner. Go to `ISSUE`.
- `ISSUE` (exactly 1 cycle):
  - `mem_read_req` = `~cmd_we`; `mem_write_req` = `cmd_we`. Both are combinational from state, and only one is ever high.
  - Go to `BUSY`.
- `BUSY`:
  - Both req outputs = 0.
  - On the first cycle with `mem_ready` = 1, at the clock edge:
    - on a read, `c<owner>_rdata` <= `mem_rdata`;
    - `c<owner>_ack` <= 1 for one cycle;
    - go to `IDLE`.
- `BUSY` is entered on the cycle after the controller has sampled the request, so `mem_ready` is already 0 there. A high `mem_ready` in `BUSY` therefore always means completion.
- `mem_addr` and `mem_wdata` are driven from the `cmd_*` registers in every state.
- Arbitration on simultaneous requests is round-robin. A `last` flag records the previous winner and the other client wins. `last` resets to 1, so client 0 wins the first tie.
- A lone requester is always granted, regardless of `last`.
- The two acks are never high together.

## Timing
- Reset (async assert, sync release):
  - state = `IDLE`, `last` = 1;
  - all outputs 0, including `mem_*_req`, both acks, both rdata and `mem_addr`.
  - A reset mid-access abandons the access: no ack is issued, and the controller resets on the same edge.
- Latency is counted from the grant cycle G (`IDLE`, request eligible, `mem_ready` = 1):
  - `ISSUE` at G+1;
  - `BUSY` from G+2;
  - if the controller holds `mem_ready` low for K cycles, `ack` is high at G+K+3.
- Back-to-back: the next grant can occur in the ack cycle itself, so there is 2 cycles of arbiter overhead between controller accesses.
- A request arriving during `ISSUE`/`BUSY` waits. No request is ever dropped.
- Client fields are sampled only in the grant cycle. They may change afterwards, but `req` must stay high until ack.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN`:
  - Defined: round-robin tie-break as described above.
  - Undefined: fixed priority. Client 0 always wins ties, and the `last` register is removed. Client 1 may starve by design (CPU-first builds).

## Test plan
- Reset, then assert `c0_req`, read at `0x00010`, with a controller model holding `mem_ready` low for K = 5 cycles → `mem_read_req` high for exactly 1 cycle at G+1, `mem_addr` = `0x00010`, and `c0_ack` high at G+8 with `c0_rdata` = model data `0xBEEF`.
- `c1` writes `0xA5A5` to `0x1FFFF` → `mem_write_req` 1 cycle, `mem_wdata` = `0xA5A5` stable until ack, `c1_ack` 1 cycle, and `c1_rdata` unchanged.
- Both clients request continuously for 4 accesses, with the macro defined → grants alternate c0, c1, c0, c1. With the macro undefined → c0, c0, c0, c0.
- Client holds `req` high through its ack cycle and drops it the cycle after → exactly one controller access per request, with no duplicate `mem_*_req`.
- Assert `rst_n` = 0 during `BUSY` → all outputs 0 immediately, no ack. After release, a new c1 request is served normally with c0 winning the first tie.
- Change `c0_addr` and `c0_wdata` on the cycle after the grant → `mem_addr` and `mem_wdata` retain the grant-cycle values until ack.
